// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINAL,
    DONE
  } div_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // DIV and REM are the signed flavours; bit 0 of the encoding marks unsigned.
  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then trial-subtract.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   i_rem,
  input  logic                  i_msb,
  input  logic [DATA_WIDTH-1:0] i_dvs,
  output logic [DATA_WIDTH:0]   o_rem,
  output logic                  o_q
);

  logic [DATA_WIDTH+1:0] w_shift;
  logic [DATA_WIDTH:0]   w_diff;

  always_comb begin
    w_shift = {i_rem, i_msb};
    o_q     = (w_shift >= {2'b00, i_dvs});
    // When the subtract is taken the difference is below the divisor, so W+1 bits suffice.
    w_diff  = w_shift[DATA_WIDTH:0] - {1'b0, i_dvs};
    o_rem   = o_q ? w_diff : w_shift[DATA_WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one quotient bit per cycle,
// fast path for divide-by-zero and signed overflow.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] div_op1,
  input  logic [DATA_WIDTH-1:0] div_op2,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [DATA_WIDTH-1:0] div_out
);

  localparam logic [DATA_WIDTH-1:0] MinVal  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OnesVal = '1;

  div_state_t            r_state;
  div_op_t               r_op;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_dvd;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic [DATA_WIDTH:0]   r_rem;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_div0;
  logic                  r_ovf;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_out;

  div_op_t               w_op;
  logic                  w_signed;
  logic                  w_s1;
  logic                  w_s2;
  logic                  w_div0;
  logic                  w_ovf;
  logic [DATA_WIDTH:0]   w_rem_nxt;
  logic                  w_q_bit;
  logic [DATA_WIDTH-1:0] w_rem_mag;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_op     = div_op_t'(div_op);
  assign w_signed = op_is_signed(w_op);
  assign w_s1     = w_signed & div_op1[DATA_WIDTH-1];
  assign w_s2     = w_signed & div_op2[DATA_WIDTH-1];
  assign w_div0   = (div_op2 == '0);
  assign w_ovf    = w_signed && (div_op1 == MinVal) && (div_op2 == OnesVal);
  assign w_rem_mag = r_rem[DATA_WIDTH-1:0];

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_msb(r_dvd[DATA_WIDTH-1]),
    .i_dvs(r_dvs),
    .o_rem(w_rem_nxt),
    .o_q  (w_q_bit)
  );

  always_comb begin
    w_result = '0;
    if (r_div0) begin
      w_result = (r_op == DIV || r_op == DIVU) ? OnesVal : r_op1;
    end else if (r_ovf) begin
      w_result = (r_op == DIV) ? MinVal : '0;
    end else begin
      unique case (r_op)
        DIV:  w_result = r_neg_q ? -r_dvd : r_dvd;
        DIVU: w_result = r_dvd;
        REM:  w_result = r_neg_r ? -w_rem_mag : w_rem_mag;
        REMU: w_result = w_rem_mag;
      endcase
    end
  end

  // r_dvd doubles as the quotient: dividend bits leave at the top as quotient bits enter below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= DIV;
      r_op1   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (div_start) begin
            r_op    <= w_op;
            r_op1   <= div_op1;
            r_dvd   <= w_s1 ? -div_op1 : div_op1;
            r_dvs   <= w_s2 ? -div_op2 : div_op2;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_rem   <= '0;
            if (w_div0 || w_ovf) begin
              r_state <= FINAL;
            end else begin
              r_cnt   <= CNT_WIDTH'(DATA_WIDTH);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[DATA_WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - CNT_WIDTH'(1);
          if (r_cnt == CNT_WIDTH'(1)) r_state <= FINAL;
        end
        FINAL: begin
          r_out   <= w_result;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_busy = (r_state != IDLE);
  assign div_done = r_done;
  assign div_out  = r_out;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_out;

  int checks   = 0;
  int failures = 0;

  div_unit #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .div_start(div_start),
    .div_op   (div_op),
    .div_op1  (div_op1),
    .div_op2  (div_op2),
    .div_busy (div_busy),
    .div_done (div_done),
    .div_out  (div_out)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension semantics written directly with SV arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        if (b == 0) return ALL_ONES;
        if (a == INT_MIN && b == ALL_ONES) return INT_MIN;
        return sa / sb;
      end
      2'b01: return (b == 0) ? ALL_ONES : a / b;
      2'b10: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == ALL_ONES) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic sgn;
    sgn = (op == 2'b00) || (op == 2'b10);
    if (b == 0 || (sgn && a == INT_MIN && b == ALL_ONES)) return 2;
    return 34;
  endfunction

  // Issue one request from a negedge; returns in the done cycle (or after the budget).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok,
                        output bit out_held);
    logic [31:0] prev;
    prev      = div_out;
    div_op    = op;
    div_op1   = a;
    div_op2   = b;
    div_start = 1'b1;
    lat       = -1;
    busy_ok   = 1'b1;
    out_held  = 1'b1;
    res       = 'x;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        div_start = 1'b0;
        div_op1   = $urandom;
        div_op2   = $urandom;
        div_op    = 2'($urandom);
      end
      if (div_done) begin
        lat = cyc;
        res = div_out;
        break;
      end
      if (!div_busy) busy_ok = 1'b0;
      if (div_out !== prev) out_held = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    div_start = 1'b0;
    div_op = 2'b00;
    div_op1 = '0;
    div_op2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (div_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b want=0", div_busy);
    end
    checks++;
    if (div_done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b want=0", div_done);
    end
    checks++;
    if (div_out !== 32'd0) begin
      failures++; $display("FAIL reset_out got=%h want=0", div_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    logic [31:0] res;
    int lat;
    bit busy_ok, held;
    run_op(2'b01, 32'd100, 32'd7, res, lat, busy_ok, held);
    checks++;
    if (res !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h want=e", res); end
    checks++;
    if (lat != 34) begin failures++; $display("FAIL divu_latency got=%0d want=34", lat); end
    checks++;
    if (!busy_ok) begin failures++; $display("FAIL divu_busy got=0 want=1 in cycles 1-33"); end
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_done got=%b want=0", div_busy);
    end
    run_op(2'b11, 32'd100, 32'd7, res, lat, busy_ok, held);
    checks++;
    if (res !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%h want=2", res); end
    @(negedge clk);
  endtask

  task automatic test_signed;
    logic [1:0]  ops [3] = '{2'b00, 2'b10, 2'b10};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] res;
    int lat;
    bit busy_ok, held;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, busy_ok, held);
      checks++;
      if (res !== exp[i] || lat != 34) begin
        failures++;
        $display("FAIL signed_%0d got=%h lat=%0d want=%h lat=34", i, res, lat, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] exp [4] = '{ALL_ONES, ALL_ONES, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] res;
    int lat;
    bit busy_ok, held;
    for (int i = 0; i < 4; i++) begin
      run_op(2'(i), 32'h1234_5678, 32'd0, res, lat, busy_ok, held);
      checks++;
      if (res !== exp[i] || lat != 2) begin
        failures++;
        $display("FAIL div_zero_op%0d got=%h lat=%0d want=%h lat=2", i, res, lat, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow;
    logic [1:0]  ops  [3] = '{2'b00, 2'b10, 2'b01};
    logic [31:0] exp  [3] = '{INT_MIN, 32'd0, 32'd0};
    int          elat [3] = '{2, 2, 34};
    logic [31:0] res;
    int lat;
    bit busy_ok, held;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], INT_MIN, ALL_ONES, res, lat, busy_ok, held);
      checks++;
      if (res !== exp[i] || lat != elat[i]) begin
        failures++;
        $display("FAIL overflow_%0d got=%h lat=%0d want=%h lat=%0d", i, res, lat, exp[i], elat[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_busy;
    int lat = -1;
    int extra = 0;
    logic [31:0] res = 'x;
    div_op = 2'b01; div_op1 = 32'd100; div_op2 = 32'd7; div_start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      div_start = (cyc == 10);
      if (cyc == 10) begin div_op = 2'b00; div_op1 = 32'd55; div_op2 = 32'd5; end
      if (div_done) begin lat = cyc; res = div_out; break; end
    end
    checks++;
    if (res !== 32'd14 || lat != 34) begin
      failures++; $display("FAIL ignore_busy got=%h lat=%0d want=e lat=34", res, lat);
    end
    div_start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL ignore_busy_extra got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid;
    int extra = 0;
    logic [31:0] res;
    int lat;
    bit busy_ok, held;
    div_op = 2'b01; div_op1 = 32'd1000; div_op2 = 32'd3; div_start = 1'b1;
    for (int cyc = 1; cyc < 20; cyc++) begin
      @(negedge clk);
      div_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (div_busy !== 1'b0 || div_out !== 32'd0) begin
      failures++; $display("FAIL reset_mid got busy=%b out=%h want busy=0 out=0", div_busy, div_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL reset_mid_done got=%0d want=0", extra); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, busy_ok, held);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat != 34) begin
      failures++; $display("FAIL after_reset got=%h lat=%0d want=ffffffff lat=34", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    bit busy_ok, held;
    run_op(2'b01, 32'd1000, 32'd10, res, lat, busy_ok, held);
    checks++;
    if (res !== 32'd100) begin failures++; $display("FAIL b2b_first got=%h want=64", res); end
    // A start presented during DONE must be dropped.
    div_op = 2'b11; div_op1 = 32'd5; div_op2 = 32'd3; div_start = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'd1000, 32'hFFFF_FFF6, res, lat, busy_ok, held);
    checks++;
    if (res !== 32'hFFFF_FF9C || lat != 34) begin
      failures++; $display("FAIL b2b_second got=%h lat=%0d want=ffffff9c lat=34", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    int lat;
    bit busy_ok, held;
    for (int n = 0; n < 800; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = INT_MIN; b = ALL_ONES; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        4: b = -($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, res, lat, busy_ok, held);
      checks++;
      if (res !== ref_result(op, a, b)) begin
        failures++;
        $display("FAIL rand_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, res,
                 ref_result(op, a, b));
      end
      checks++;
      if (lat != ref_latency(op, a, b)) begin
        failures++;
        $display("FAIL rand_latency op=%0d a=%h b=%h got=%0d want=%0d", op, a, b, lat,
                 ref_latency(op, a, b));
      end
      checks++;
      if (!busy_ok) begin failures++; $display("FAIL rand_busy op=%0d got=0 want=1", op); end
      checks++;
      if (!held) begin failures++; $display("FAIL rand_out_held op=%0d got=changed want=held", op); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
